// File: rtl/axi_lite_sram_slave_if.sv
// AXI4-Lite bus bundle shared by the bridge arbiter (master) and the SRAM responder (slave).
interface AXI4_Lite;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder backed by a word-addressed SRAM array; one outstanding transaction.
// Define AXI_SRAM_RAND_LAT_EN to replace LATENCY with an LFSR-driven 1..8 cycle latency.
module axi_lite_sram_slave #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input logic     clk,
  input logic     rst_n,
  AXI4_Lite.slave s_if
);

  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, W_COLLECT, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_next;

  logic        is_read;
  logic        aw_got;
  logic        w_got;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic        bvalid_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        ready_ar;
  logic        ready_aw;
  logic        ready_w;
  logic        ar_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        req_done;
  logic        enter_resp;
  logic        resp_done;
  logic [3:0]  lat_m1;

  logic        eff_read;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic [3:0]  eff_wstrb;
  logic [31:0] offset;
  logic        in_range;
  logic [IDX_W-1:0] idx;

`ifdef AXI_SRAM_RAND_LAT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign lat_m1 = {1'b0, lfsr[2:0]};
`else
  assign lat_m1 = 4'(LATENCY - 1);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A request completing with zero residual latency jumps straight to RESP on its accept edge.
  always_comb begin
    state_next = state;
    ready_ar   = 1'b0;
    ready_aw   = 1'b0;
    ready_w    = 1'b0;
    req_done   = 1'b0;
    enter_resp = 1'b0;
    resp_done  = 1'b0;

    case (state)
      IDLE: begin
        ready_ar = 1'b1;
        ready_aw = !s_if.arvalid;
        ready_w  = !s_if.arvalid;
      end
      W_COLLECT: begin
        ready_aw = !aw_got;
        ready_w  = !w_got;
      end
      default: ;
    endcase

    ar_hs = ready_ar && s_if.arvalid;
    aw_hs = ready_aw && s_if.awvalid;
    w_hs  = ready_w && s_if.wvalid;

    case (state)
      IDLE: begin
        if (ar_hs || (aw_hs && w_hs)) begin
          req_done = 1'b1;
        end else if (aw_hs || w_hs) begin
          state_next = W_COLLECT;
        end
      end
      W_COLLECT: begin
        if ((aw_got || aw_hs) && (w_got || w_hs)) begin
          req_done = 1'b1;
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (is_read ? s_if.rready : s_if.bready) begin
          resp_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (req_done) begin
      if (lat_m1 == 4'd0) begin
        enter_resp = 1'b1;
      end else begin
        state_next = WAIT;
      end
    end
    if (enter_resp) begin
      state_next = RESP;
    end
  end

  // Channels handshaking on this edge are used directly so the array can be accessed on the accept edge.
  assign eff_read  = ar_hs || is_read;
  assign eff_addr  = ar_hs ? s_if.araddr : (aw_hs ? s_if.awaddr : addr_q);
  assign eff_wdata = w_hs ? s_if.wdata : wdata_q;
  assign eff_wstrb = w_hs ? s_if.wstrb : wstrb_q;
  assign offset    = eff_addr - BASE_ADDR;
  assign in_range  = (eff_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign idx       = offset[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_read  <= 1'b0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      cnt      <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      rdata_q  <= 32'd0;
      rresp_q  <= OKAY;
      bresp_q  <= OKAY;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      if (ar_hs) begin
        addr_q  <= s_if.araddr;
        is_read <= 1'b1;
      end
      if (aw_hs) begin
        addr_q <= s_if.awaddr;
        aw_got <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= s_if.wdata;
        wstrb_q <= s_if.wstrb;
        w_got   <= 1'b1;
      end

      if (req_done) begin
        cnt <= lat_m1;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (enter_resp) begin
        if (eff_read) begin
          rdata_q  <= in_range ? mem[idx] : 32'd0;
          rresp_q  <= in_range ? OKAY : SLVERR;
          rvalid_q <= 1'b1;
        end else begin
          bresp_q  <= in_range ? OKAY : SLVERR;
          bvalid_q <= 1'b1;
        end
      end

      if (resp_done) begin
        rvalid_q <= 1'b0;
        bvalid_q <= 1'b0;
        is_read  <= 1'b0;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end
    end
  end

  // The array has no reset so its contents survive rst_n; a write caught by reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && !eff_read && in_range) begin
      if (eff_wstrb[0]) mem[idx][7:0]   <= eff_wdata[7:0];
      if (eff_wstrb[1]) mem[idx][15:8]  <= eff_wdata[15:8];
      if (eff_wstrb[2]) mem[idx][23:16] <= eff_wdata[23:16];
      if (eff_wstrb[3]) mem[idx][31:24] <= eff_wdata[31:24];
    end
  end

  assign s_if.arready = ready_ar;
  assign s_if.awready = ready_aw;
  assign s_if.wready  = ready_w;
  assign s_if.rvalid  = rvalid_q;
  assign s_if.rdata   = rdata_q;
  assign s_if.rresp   = rresp_q;
  assign s_if.bvalid  = bvalid_q;
  assign s_if.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Bench for axi_lite_sram_slave: two instances (LATENCY 1 and 3) behind one shared driver,
// checked against an array model of the memory built from the address-decode and byte-strobe rules.
module tb_axi_lite_sram_slave;

  localparam int unsigned DEPTH     = 4096;
  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam logic [31:0] RAND_BASE = 32'h8000_0100;
  localparam int          LAT_A     = 1;
  localparam int          LAT_B     = 3;
  localparam int          N_RAND    = 1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sel;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, awvalid, wvalid, rready, bready;
  logic [3:0]  wstrb;
  logic        arready, awready, wready, rvalid, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model_a [DEPTH];
  logic [31:0] model_b [DEPTH];

  AXI4_Lite bus_a ();
  AXI4_Lite bus_b ();

  axi_lite_sram_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT_A)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .s_if (bus_a)
  );

  axi_lite_sram_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT_B)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .s_if (bus_b)
  );

  assign bus_a.araddr  = araddr;
  assign bus_a.awaddr  = awaddr;
  assign bus_a.wdata   = wdata;
  assign bus_a.wstrb   = wstrb;
  assign bus_a.arvalid = arvalid && !sel;
  assign bus_a.awvalid = awvalid && !sel;
  assign bus_a.wvalid  = wvalid && !sel;
  assign bus_a.rready  = rready && !sel;
  assign bus_a.bready  = bready && !sel;
  assign bus_b.araddr  = araddr;
  assign bus_b.awaddr  = awaddr;
  assign bus_b.wdata   = wdata;
  assign bus_b.wstrb   = wstrb;
  assign bus_b.arvalid = arvalid && sel;
  assign bus_b.awvalid = awvalid && sel;
  assign bus_b.wvalid  = wvalid && sel;
  assign bus_b.rready  = rready && sel;
  assign bus_b.bready  = bready && sel;

  assign arready = sel ? bus_b.arready : bus_a.arready;
  assign awready = sel ? bus_b.awready : bus_a.awready;
  assign wready  = sel ? bus_b.wready  : bus_a.wready;
  assign rvalid  = sel ? bus_b.rvalid  : bus_a.rvalid;
  assign bvalid  = sel ? bus_b.bvalid  : bus_a.bvalid;
  assign rdata   = sel ? bus_b.rdata   : bus_a.rdata;
  assign rresp   = sel ? bus_b.rresp   : bus_a.rresp;
  assign bresp   = sel ? bus_b.bresp   : bus_a.bresp;

  initial begin
    #800_000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 4) < DEPTH);
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    return in_range(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned i;
    if (!in_range(a)) return 32'd0;
    i = (a - BASE) / 4;
    return sel ? model_b[i] : model_a[i];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned i;
    logic [31:0] w;
    if (!in_range(a)) return;
    i = (a - BASE) / 4;
    w = sel ? model_b[i] : model_a[i];
    for (int b = 0; b < 4; b++) begin
      if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    end
    if (sel) model_b[i] = w;
    else     model_a[i] = w;
  endtask

  function automatic int cur_lat();
    return sel ? LAT_B : LAT_A;
  endfunction

  task automatic check_latency(input string tag, input int lat);
`ifdef AXI_SRAM_RAND_LAT_EN
    check_output(tag, 32'(lat >= 1 && lat <= 8), 32'd1);
`else
    check_output(tag, 32'(lat), 32'(cur_lat()));
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_arready"}, 32'(arready), 32'd1);
    check_output({tag, "_awready"}, 32'(awready), 32'd1);
    check_output({tag, "_wready"},  32'(wready),  32'd1);
    check_output({tag, "_rvalid"},  32'(rvalid),  32'd0);
    check_output({tag, "_bvalid"},  32'(bvalid),  32'd0);
    check_output({tag, "_rdata"},   rdata,        32'd0);
    check_output({tag, "_rresp"},   32'(rresp),   32'd0);
    check_output({tag, "_bresp"},   32'(bresp),   32'd0);
  endtask

  task automatic select_dut(input logic s);
    @(negedge clk);
    sel = s;
  endtask

  // Ends on the negedge where rvalid is seen; the response handshakes on the following edge.
  task automatic apply_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp,
                            output int lat);
    int n = 0;
    @(negedge clk);
    araddr  = a;
    arvalid = 1'b1;
    rready  = 1'b1;
    #1;
    while (!arready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output("ar_accept", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_output("r_arrival", 32'(rvalid), 32'd1);
    data = rdata;
    resp = rresp;
  endtask

  task automatic apply_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int lat);
    int n = 0;
    @(negedge clk);
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    bready  = 1'b1;
    #1;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output("aw_w_accept", 32'(awready && wready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    lat = 1;
    while (!bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_output("b_arrival", 32'(bvalid), 32'd1);
    resp = bresp;
  endtask

  task automatic read_and_check(input string tag, input logic [31:0] a);
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    apply_read(a, d, r, lat);
    check_output({tag, "_rdata"}, d, model_read(a));
    check_output({tag, "_rresp"}, 32'(r), 32'(model_resp(a)));
    check_latency({tag, "_rlat"}, lat);
  endtask

  task automatic write_and_check(input string tag, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s);
    logic [1:0] r;
    int         lat;
    apply_write(a, d, s, r, lat);
    model_write(a, d, s);
    check_output({tag, "_bresp"}, 32'(r), 32'(model_resp(a)));
    check_latency({tag, "_blat"}, lat);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r  = $urandom_range(0, 15);
    logic [31:0] lo = 32'($urandom_range(0, 3));
    if (r == 0) return BASE - 32'd4 * 32'($urandom_range(1, 8)) + lo;
    if (r == 1) return BASE + 32'(DEPTH) * 32'd4 + 32'd4 * 32'($urandom_range(0, 8)) + lo;
    return RAND_BASE + 32'd4 * 32'($urandom_range(0, 31)) + lo;
  endfunction

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    logic [31:0] held;

    sel     = 1'b0;
    araddr  = 32'd0;
    awaddr  = 32'd0;
    wdata   = 32'd0;
    wstrb   = 4'd0;
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    rready  = 1'b1;
    bready  = 1'b1;
    rst_n   = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset_a");
    sel = 1'b1;
    #1;
    check_reset_values("reset_b");
    sel   = 1'b0;
    rst_n = 1'b1;

    // Full write then read back on the LATENCY=1 instance.
    write_and_check("wr_full", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    read_and_check("rd_full", 32'h8000_0010);
    check_output("rd_full_lit", rdata, 32'hDEAD_BEEF);

    // Partial strobe merges into the existing word.
    write_and_check("wr_part", 32'h8000_0010, 32'h1122_3344, 4'b0101);
    read_and_check("rd_part", 32'h8000_0010);
    check_output("rd_part_lit", rdata, 32'hDE22_BE44);

    // Zero strobe completes OKAY and changes nothing.
    write_and_check("wr_nostrb", 32'h8000_0010, 32'hFFFF_FFFF, 4'h0);
    read_and_check("rd_nostrb", 32'h8000_0010);

    // Out-of-range on both sides of the array, with in-range neighbours.
    write_and_check("wr_lo_nb", 32'h8000_0000, 32'h0123_4567, 4'hF);
    write_and_check("wr_hi_nb", 32'h8000_3FFC, 32'h89AB_CDEF, 4'hF);
    read_and_check("rd_hi_nb", 32'h8000_3FFC);
    read_and_check("rd_oor_lo", 32'h7FFF_FFFC);
    check_output("rd_oor_lo_lit", 32'(rresp), 32'd2);
    read_and_check("rd_oor_hi", BASE + 32'(DEPTH) * 32'd4);
    write_and_check("wr_oor_lo", 32'h7FFF_FFFC, 32'hA5A5_A5A5, 4'hF);
    write_and_check("wr_oor_hi", BASE + 32'(DEPTH) * 32'd4, 32'h5A5A_5A5A, 4'hF);
    read_and_check("rd_lo_nb", 32'h8000_0000);
    read_and_check("rd_hi_nb2", 32'h8000_3FFC);

    // Simultaneous AR and AW/W: read first, stalled by rready, then the write.
    @(negedge clk);
    araddr  = 32'h8000_0010;
    arvalid = 1'b1;
    awaddr  = 32'h8000_0030;
    wdata   = 32'h5555_AAAA;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    rready  = 1'b0;
    bready  = 1'b1;
    #1;
    check_output("both_arready", 32'(arready), 32'd1);
    check_output("both_awready", 32'(awready), 32'd0);
    check_output("both_wready",  32'(wready),  32'd0);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_latency("both_rlat", lat);
    held = model_read(32'h8000_0010);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check_output($sformatf("stall_rvalid_%0d", k),  32'(rvalid),  32'd1);
      check_output($sformatf("stall_rdata_%0d", k),   rdata,        held);
      check_output($sformatf("stall_awready_%0d", k), 32'(awready), 32'd0);
      check_output($sformatf("stall_bvalid_%0d", k),  32'(bvalid),  32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    #1;
    check_output("post_rd_rvalid",  32'(rvalid),  32'd0);
    check_output("post_rd_awready", 32'(awready), 32'd1);
    check_output("post_rd_wready",  32'(wready),  32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    lat = 1;
    while (!bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_latency("both_blat", lat);
    check_output("both_bresp", 32'(bresp), 32'd0);
    model_write(32'h8000_0030, 32'h5555_AAAA, 4'hF);
    read_and_check("rd_both_wr", 32'h8000_0030);

    // Split AW/W on the LATENCY=3 instance: AW in cycle 0, W in cycle 4.
    select_dut(1'b1);
    awaddr  = 32'h8000_0040;
    awvalid = 1'b1;
    wvalid  = 1'b0;
    bready  = 1'b1;
    #1;
    check_output("split_aw_ready", 32'(awready), 32'd1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      awvalid = 1'b0;
      if (c == 4) begin
        wdata  = 32'hCAFE_F00D;
        wstrb  = 4'hF;
        wvalid = 1'b1;
      end else begin
        wvalid = 1'b0;
      end
      #1;
      if (c <= 4) begin
        check_output($sformatf("split_awready_c%0d", c), 32'(awready), 32'd0);
        check_output($sformatf("split_wready_c%0d", c),  32'(wready),  32'd1);
      end
`ifndef AXI_SRAM_RAND_LAT_EN
      check_output($sformatf("split_bvalid_c%0d", c), 32'(bvalid), 32'(c >= 4 + LAT_B));
`endif
    end
    model_write(32'h8000_0040, 32'hCAFE_F00D, 4'hF);
    check_output("split_bresp", 32'(bresp), 32'd0);
    read_and_check("rd_split", 32'h8000_0040);

    // Reset while a write to 0x8000_0020 is waiting out its latency.
    write_and_check("wr_old", 32'h8000_0020, 32'h0BAD_F00D, 4'hF);
    @(negedge clk);
    awaddr  = 32'h8000_0020;
    wdata   = 32'hFFFF_0000;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    #1;
    check_output("rstw_accept", 32'(awready && wready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
`ifndef AXI_SRAM_RAND_LAT_EN
    check_output("rstw_in_wait", 32'(bvalid), 32'd0);
`else
    if (bvalid) model_write(32'h8000_0020, 32'hFFFF_0000, 4'hF);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_values("rst_mid");
    rst_n = 1'b1;
    read_and_check("rd_after_rst", 32'h8000_0020);

    // Randomized traffic on the LATENCY=1 instance over a 32-word window plus stray out-of-range hits.
    select_dut(1'b0);
    for (int i = 0; i < 32; i++) begin
      write_and_check("rnd_init", RAND_BASE + 32'(i) * 32'd4, $urandom, 4'hF);
    end
    for (int i = 0; i < N_RAND; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        read_and_check("rnd_rd", rand_addr());
      end else begin
        write_and_check("rnd_wr", rand_addr(), $urandom, 4'($urandom_range(0, 15)));
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_lite_sram_slave.md
# axi_lite_sram_slave

AXI4-Lite responder that terminates the CPU memory bus: it accepts one read or one write at a time from the pipelined bridge arbiter's master port and answers from an internal word-addressed SRAM array. Response latency is programmable, so the bench can exercise the arbiter and the IFU/LSU wait paths. Single outstanding transaction; no reordering.

## Interface
- `DEPTH_WORDS`, 4096: number of 32-bit words in the array.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0.
- `LATENCY`, 1: cycles from the address/data accept edge to response-valid; legal range 1..15.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_if`  AXI4_Lite.slave  —  bus port; fields as seen by this block:
  - `araddr`/`awaddr` in 32; `arvalid`/`awvalid`/`wvalid` in 1; `wdata` in 32; `wstrb` in 4; `rready`/`bready` in 1.
  - `arready`/`awready`/`wready` out 1; `rvalid`/`bvalid` out 1; `rdata` out 32; `rresp`/`bresp` out 2.

## Operation
- States: `IDLE`, `W_COLLECT`, `WAIT`, `RESP`. Flags `is_read`, `aw_got`, `w_got`; latency counter `cnt[3:0]`.
- `IDLE`: `arready=1`; `awready=wready=!arvalid`.
  - AR handshake: latch address, `is_read=1`.
  - AW and/or W handshake with no `arvalid`: latch the captured channel(s).
  - If `arvalid` and `awvalid` are both high, the read wins and the write waits.
- `W_COLLECT`: entered when exactly one of AW/W has been captured. The missing channel's ready stays 1; the other ready is 0. Leaves when the missing channel handshakes.
- On a full request (AR, or AW+W), load `cnt = LATENCY-1`. If `cnt==0` go to `RESP`, else go to `WAIT`.
- `WAIT`: decrement `cnt`; at `cnt==1` transition to `RESP`. All readies are 0.
- Array access happens on the edge entering `RESP`:
  - Read: register `rdata` from the array.
  - Write: commit bytes where `wstrb[i]=1` (byte i = `wdata[8i+7:8i]`).
- Decode: `idx = (addr - BASE_ADDR) >> 2`. `addr[1:0]` is ignored.
  - Out of range (`addr < BASE_ADDR` or `idx >= DEPTH_WORDS`): resp = 2'b10 (SLVERR), `rdata=0`, write discarded.
  - In range: resp = 2'b00.
- `RESP`: `rvalid` (read) or `bvalid` (write) is 1. `rdata`/`rresp`/`bresp` are held stable until `rready`/`bready`. On that handshake go to `IDLE`.
- The array is not reset. Contents survive `rst_n`.

## Timing
- Reset values: `arready=awready=wready=1`, `rvalid=bvalid=0`, `rdata=0`, `rresp=bresp=2'b00`, state `IDLE`, flags cleared.
- `IDLE` readies are driven combinationally from state and `arvalid`. All other outputs are registered.
- Latency: a handshake on edge N gives valid high from cycle N+LATENCY. A split AW/W counts from the later handshake.
- Minimum per transaction is LATENCY+1 cycles, because `IDLE` re-opens the cycle after the response handshake.
- A response stalled by `rready=0` holds indefinitely, with no timeout.
- Reset asserted mid-transaction (any state): next edge forces `IDLE` and the reset values above.
  - A write not yet in `RESP` is dropped.
  - A write already committed stays in the array.
- `wstrb=0` write: completes with OKAY and changes nothing.

## Configuration
- `AXI_SRAM_RAND_LAT_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on reset and advances every cycle.
  - Each accepted request uses latency `1 + lfsr[2:0]` (1..8) in place of `LATENCY`.
  - `LATENCY` is ignored.
- Not defined: fixed `LATENCY`; no LFSR logic is present.

## Test plan
- Reset, `LATENCY=1`: write `awaddr=wdata` addr 32'h8000_0010, data 32'hDEAD_BEEF, `wstrb=4'hF`, same cycle.
  - Required: `bvalid` one cycle later with `bresp=00`.
  - Then a read of the same address returns `rdata=32'hDEAD_BEEF`, `rresp=00`, `rvalid` one cycle after AR.
- Partial write `wstrb=4'b0101`, data 32'h1122_3344, over 32'hDEAD_BEEF.
  - Required: subsequent read returns 32'hDE22_BE44.
- Split write, `LATENCY=3`: AW at cycle 0, W at cycle 4.
  - Required: `awready=0` during cycles 1–4, `wready=1` during cycles 1–4, `bvalid` at cycle 7.
- Out-of-range read at 32'h7FFF_FFFC and at `BASE+4*DEPTH_WORDS`.
  - Required: `rresp=10`, `rdata=0`.
  - An out-of-range write returns `bresp=10`; rereading in-range neighbours shows them unchanged.
- `arvalid` and `awvalid` together in `IDLE`.
  - Required: read serviced first with `awready=0`; write accepted in the first `IDLE` cycle after `rvalid&&rready`.
  - With `rready` held low for 5 cycles, `rvalid`/`rdata` stay stable.
- `rst_n=0` asserted while in `WAIT` on a write to 32'h8000_0020.
  - Required: next cycle all outputs at reset values; a read afterwards returns the old word.
  - With `AXI_SRAM_RAND_LAT_EN`: 1000 random reads each complete within 1..8 cycles.
